// File: rtl/bitrev_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bitrev_ctrl_pkg : state encoding and frame-length helper for bitrev_ctrl
// Revision: 1.0
// ----------------------------------------------------------------------------
package bitrev_ctrl_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  // One frame is 2^(LGSIZE-1) clock-enables, each carrying a sample pair.
  function automatic int frame_len(input int lgsize);
    return 1 << (lgsize - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bitrev_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bitrev_ctrl : valid/ready sequencer driving the bit-reversal buffer ce/reset
// Revision: 1.0
// ----------------------------------------------------------------------------
module bitrev_ctrl
  import bitrev_ctrl_pkg::*;
#(
  parameter int LGSIZE = 5
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_s_valid,
  output logic o_s_ready,
  input  logic i_flush,
  input  logic i_m_ready,
  output logic o_m_valid,
  output logic o_m_first,
  output logic o_m_last,
  output logic o_br_ce,
  output logic o_br_reset,
  output logic o_zero_in,
  input  logic i_br_sync,
  output logic o_sync_err,
  output logic o_busy
);

  localparam int N  = frame_len(LGSIZE);
  localparam int CW = LGSIZE - 1;

  logic [1:0]        state, state_nx;
  logic [CW-1:0]     in_cnt, in_cnt_nx, out_cnt;
  logic [LGSIZE-1:0] drain_cnt, drain_init;
  logic              m_valid, primed, br_reset, sync_err;
  logic              out_free, out_hs, ce, s_ready, zero_in;
  logic              flush_go, drain_done;

  assign out_free   = !m_valid || i_m_ready;
  assign out_hs     = m_valid && i_m_ready;
  assign flush_go   = i_flush && ((state == FILL) || (state == RUN));
  assign drain_done = (state == DRAIN) && (drain_cnt == '0) && out_free;
  assign in_cnt_nx  = ce ? in_cnt + 1'b1 : in_cnt;

  // 2N equals 2^LGSIZE, so modular negation of in_cnt yields 2N - in_cnt.
  assign drain_init = (in_cnt_nx == '0) ? LGSIZE'(N)
                                        : LGSIZE'(0) - {1'b0, in_cnt_nx};

  // Acceptance is held off while the buffer is in its synchronous reset.
  always_comb begin
    s_ready = 1'b0;
    ce      = 1'b0;
    zero_in = 1'b0;
    case (state)
      IDLE, FILL: begin
        s_ready = !br_reset;
        ce      = i_s_valid && !br_reset;
      end
      RUN: begin
        s_ready = out_free;
        ce      = i_s_valid && out_free;
      end
      DRAIN: begin
        zero_in = 1'b1;
        ce      = out_free && (drain_cnt != '0);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (ce) state_nx = FILL;
      FILL: begin
        if (flush_go)                 state_nx = DRAIN;
        else if (ce && in_cnt == '1)  state_nx = RUN;
      end
      RUN:   if (flush_go)   state_nx = DRAIN;
      DRAIN: if (drain_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      in_cnt    <= '0;
      out_cnt   <= '0;
      drain_cnt <= '0;
      m_valid   <= 1'b0;
      primed    <= 1'b0;
      br_reset  <= 1'b1;
      sync_err  <= 1'b0;
    end else begin
      state  <= state_nx;
      in_cnt <= in_cnt_nx;
      if (out_hs)
        out_cnt <= out_cnt + 1'b1;
      if (flush_go)
        drain_cnt <= drain_init;
      else if ((state == DRAIN) && ce)
        drain_cnt <= drain_cnt - 1'b1;
      // primed: the buffer holds one complete frame, so each ce yields output
      if (ce && (in_cnt == '1))
        primed <= 1'b1;
      else if (drain_done)
        primed <= 1'b0;
      if (ce && primed)
        m_valid <= 1'b1;
      else if (out_hs)
        m_valid <= 1'b0;
      br_reset <= drain_done;
      if (m_valid && (i_br_sync != (out_cnt == '0)))
        sync_err <= 1'b1;
    end
  end

  assign o_s_ready  = s_ready;
  assign o_br_ce    = ce;
  assign o_zero_in  = zero_in;
  assign o_m_valid  = m_valid;
  assign o_m_first  = m_valid && (out_cnt == '0);
  assign o_m_last   = m_valid && (out_cnt == '1);
  assign o_br_reset = br_reset;
  assign o_sync_err = sync_err;
  assign o_busy     = (state != IDLE);

endmodule
`default_nettype wire
